pkt_out_mux: RTL and testbench

PKT_OUT_MUX -- requirements
Module: pkt_out_mux

---
 rtl/pkt_out_mux.sv | 217 +++++++++++++++++++++
 tb/tb_pkt_out_mux.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_out_mux.sv
// pkt_out_mux: merges the configuration-responder and forwarding-datapath packet
// streams onto one output, whole packets at a time, through per-input admission FIFOs.
module pkt_out_mux #(
    parameter int FIFO_DEPTH    = 32,
    parameter int MAX_PKT_WORDS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         conf_valid,
    input  logic [133:0] conf_data,
    input  logic         pkt_valid,
    input  logic [133:0] pkt_data,
    output logic         data_out_valid,
    output logic [133:0] data_out,
    input  logic         data_out_ready,
    output logic [15:0]  drop_cnt_conf,
    output logic [15:0]  drop_cnt_pkt,
    output logic [15:0]  err_cnt
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ADMIT_MAX  = (AW+1)'(FIFO_DEPTH - MAX_PKT_WORDS);

    localparam logic [1:0] WT_HEAD = 2'b01;
    localparam logic [1:0] WT_MID  = 2'b11;
    localparam logic [1:0] WT_TAIL = 2'b10;

    localparam logic [1:0] IN_IDLE   = 2'd0;
    localparam logic [1:0] IN_ACCEPT = 2'd1;
    localparam logic [1:0] IN_DROP   = 2'd2;

    localparam logic [1:0] OUT_IDLE = 2'd0;
    localparam logic [1:0] OUT_CONF = 2'd1;
    localparam logic [1:0] OUT_PKT  = 2'd2;

    // Index 0 is the conf source, index 1 the pkt source throughout.
    logic [1:0]          in_valid_q, in_valid_d;
    logic [1:0][133:0]   in_data_q, in_data_d;
    logic [1:0][1:0]     in_state_q, in_state_d;
    logic [1:0][AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0][AW:0]    count_s;
    logic [1:0]          empty_s, wr_en_s, pop_s, err_inc_s, drop_inc_s;
    logic [1:0][15:0]    drop_cnt_q, drop_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [16:0]         err_sum_s;
    logic [1:0]          out_state_q, out_state_d;
    logic                last_pkt_q, last_pkt_d;
    logic                data_out_valid_q, data_out_valid_d;
    logic [133:0]        data_out_q, data_out_d;
    logic                src_s;
    logic [133:0]        head_word_s;
    logic [133:0]        mem_q [2][FIFO_DEPTH];

    // Input capture stage and FIFO occupancy.
    always_comb begin
        in_valid_d   = {pkt_valid, conf_valid};
        in_data_d[0] = conf_data;
        in_data_d[1] = pkt_data;
        for (int s = 0; s < 2; s++) begin
            count_s[s]  = wr_ptr_q[s] - rd_ptr_q[s];
            empty_s[s]  = (count_s[s] == {(AW+1){1'b0}});
            wr_ptr_d[s] = wr_ptr_q[s] + {{AW{1'b0}}, wr_en_s[s]};
            rd_ptr_d[s] = rd_ptr_q[s] + {{AW{1'b0}}, pop_s[s]};
        end
    end

    // Per-input admission: a packet is admitted only when its worst-case length fits.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            in_state_d[s] = in_state_q[s];
            wr_en_s[s]    = 1'b0;
            err_inc_s[s]  = 1'b0;
            drop_inc_s[s] = 1'b0;
            if (in_valid_q[s]) begin
                case (in_state_q[s])
                    IN_IDLE: begin
                        if (in_data_q[s][133:132] != WT_HEAD) begin
                            err_inc_s[s] = 1'b1;
                        end else if (count_s[s] <= ADMIT_MAX) begin
                            wr_en_s[s]    = 1'b1;
                            in_state_d[s] = IN_ACCEPT;
                        end else begin
                            drop_inc_s[s] = 1'b1;
                            in_state_d[s] = IN_DROP;
                        end
                    end
                    IN_ACCEPT: begin
                        if (count_s[s] == FULL_COUNT) begin
                            // A discarded tail already closes the packet; do not swallow the next one.
                            err_inc_s[s]  = 1'b1;
                            in_state_d[s] = (in_data_q[s][133:132] == WT_TAIL) ? IN_IDLE : IN_DROP;
                        end else begin
                            case (in_data_q[s][133:132])
                                WT_HEAD: begin
                                    wr_en_s[s]   = 1'b1;
                                    err_inc_s[s] = 1'b1;
                                end
                                WT_MID:  wr_en_s[s] = 1'b1;
                                WT_TAIL: begin
                                    wr_en_s[s]    = 1'b1;
                                    in_state_d[s] = IN_IDLE;
                                end
                                default: err_inc_s[s] = 1'b1;
                            endcase
                        end
                    end
                    IN_DROP: begin
                        if (in_data_q[s][133:132] == WT_TAIL) begin
                            in_state_d[s] = IN_IDLE;
                        end else begin
                            in_state_d[s] = IN_DROP;
                        end
                    end
                    default: in_state_d[s] = IN_IDLE;
                endcase
            end else begin
                in_state_d[s] = in_state_q[s];
            end
        end
    end

    // Output arbitration and register: whole packets, round-robin between sources.
    always_comb begin
        out_state_d      = out_state_q;
        last_pkt_d       = last_pkt_q;
        data_out_valid_d = data_out_valid_q & ~data_out_ready;
        data_out_d       = data_out_q;
        pop_s            = 2'b00;
        case (out_state_q)
            OUT_IDLE: begin
                if (!empty_s[0] && !empty_s[1]) begin
                    src_s = ~last_pkt_q;
                end else begin
                    src_s = ~empty_s[1];
                end
            end
            OUT_CONF: src_s = 1'b0;
            OUT_PKT:  src_s = 1'b1;
            default: begin
                src_s       = 1'b0;
                out_state_d = OUT_IDLE;
            end
        endcase
        head_word_s = mem_q[src_s][rd_ptr_q[src_s][AW-1:0]];
        if ((!data_out_valid_q || data_out_ready) && !empty_s[src_s]) begin
            pop_s[src_s]     = 1'b1;
            data_out_valid_d = 1'b1;
            data_out_d       = head_word_s;
            last_pkt_d       = src_s;
            if (head_word_s[133:132] == WT_TAIL) begin
                out_state_d = OUT_IDLE;
            end else begin
                out_state_d = src_s ? OUT_PKT : OUT_CONF;
            end
        end else begin
            last_pkt_d = last_pkt_q;
        end
    end

    // Saturating statistics counters.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            if (drop_inc_s[s] && (drop_cnt_q[s] != 16'hFFFF)) begin
                drop_cnt_d[s] = drop_cnt_q[s] + 16'd1;
            end else begin
                drop_cnt_d[s] = drop_cnt_q[s];
            end
        end
        err_sum_s = {1'b0, err_cnt_q} + {16'd0, err_inc_s[0]} + {16'd0, err_inc_s[1]};
        err_cnt_d = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
    end

    // FIFO storage; occupancy lives in the pointers so the array needs no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (wr_en_s[s]) begin
                mem_q[s][wr_ptr_q[s][AW-1:0]] <= in_data_q[s];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_valid_q       <= 2'b00;
            in_data_q        <= '0;
            in_state_q       <= {IN_IDLE, IN_IDLE};
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            drop_cnt_q       <= '0;
            err_cnt_q        <= 16'd0;
            out_state_q      <= OUT_IDLE;
            last_pkt_q       <= 1'b1;
            data_out_valid_q <= 1'b0;
            data_out_q       <= 134'd0;
        end else begin
            in_valid_q       <= in_valid_d;
            in_data_q        <= in_data_d;
            in_state_q       <= in_state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            drop_cnt_q       <= drop_cnt_d;
            err_cnt_q        <= err_cnt_d;
            out_state_q      <= out_state_d;
            last_pkt_q       <= last_pkt_d;
            data_out_valid_q <= data_out_valid_d;
            data_out_q       <= data_out_d;
        end
    end

    assign data_out_valid = data_out_valid_q;
    assign data_out       = data_out_q;
    assign drop_cnt_conf  = drop_cnt_q[0];
    assign drop_cnt_pkt   = drop_cnt_q[1];
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_pkt_out_mux.sv
// Self-checking bench for pkt_out_mux: directed scenarios plus a randomized
// two-source run scored against per-source packet streams.
module tb_pkt_out_mux;
    localparam logic [1:0] WT_HEAD = 2'b01;
    localparam logic [1:0] WT_MID  = 2'b11;
    localparam logic [1:0] WT_TAIL = 2'b10;

    typedef logic [133:0] word_q_t[$];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         conf_valid = 1'b0;
    logic [133:0] conf_data = '0;
    logic         pkt_valid = 1'b0;
    logic [133:0] pkt_data = '0;
    logic         data_out_ready = 1'b0;
    logic         data_out_valid;
    logic [133:0] data_out;
    logic [15:0]  drop_cnt_conf, drop_cnt_pkt, err_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [133:0] out_q[$];
    int           out_cyc[$];

    always #5 clk = ~clk;

    pkt_out_mux #(.FIFO_DEPTH(32), .MAX_PKT_WORDS(8)) dut (
        .clk(clk), .reset(reset),
        .conf_valid(conf_valid), .conf_data(conf_data),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .data_out_valid(data_out_valid), .data_out(data_out),
        .data_out_ready(data_out_ready),
        .drop_cnt_conf(drop_cnt_conf), .drop_cnt_pkt(drop_cnt_pkt), .err_cnt(err_cnt)
    );

    always @(posedge clk) cyc++;

    // Output monitor: a word counts as delivered when valid and ready hold mid-cycle.
    always @(negedge clk) begin
        if (!reset && data_out_valid && data_out_ready) begin
            out_q.push_back(data_out);
            out_cyc.push_back(cyc);
        end
    end

    function automatic logic [133:0] make_word(input logic [1:0] t);
        return {t, 4'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic word_q_t make_pkt(input int len);
        word_q_t p;
        for (int i = 0; i < len; i++)
            p.push_back(make_word(i == 0 ? WT_HEAD : (i == len - 1 ? WT_TAIL : WT_MID)));
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        conf_valid = 1'b0;
        pkt_valid = 1'b0;
        data_out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        out_q.delete();
        out_cyc.delete();
        tick();
    endtask

    task automatic wait_out(input int n, input int limit);
        for (int i = 0; i < limit && out_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        conf_valid = 1'b1;
        conf_data = make_word(WT_HEAD);
        data_out_ready = 1'b1;
        tick();
        tick();
        checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
        checks++; if (data_out !== 134'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", data_out); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        checks++; if (drop_cnt_conf !== 16'd0) begin failures++; $display("FAIL reset_drop_conf: got %0d expected 0", drop_cnt_conf); end
        checks++; if (drop_cnt_pkt !== 16'd0) begin failures++; $display("FAIL reset_drop_pkt: got %0d expected 0", drop_cnt_pkt); end
        do_reset();
    endtask

    task automatic test_single_conf();
        word_q_t p = make_pkt(5);
        do_reset();
        data_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            conf_valid = 1'b1;
            conf_data = p[i];
            tick();
            if (i == 1) begin
                checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL latency_early: got valid=%b expected 0", data_out_valid); end
            end
            if (i == 2) begin
                checks++;
                if (data_out_valid !== 1'b1 || data_out !== p[0]) begin
                    failures++; $display("FAIL latency_first: got valid=%b data=%h expected valid=1 data=%h", data_out_valid, data_out, p[0]);
                end
            end
        end
        conf_valid = 1'b0;
        wait_out(5, 50);
        checks++; if (out_q.size() != 5) begin failures++; $display("FAIL single_count: got %0d expected 5", out_q.size()); end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            checks++; if (out_q[i] !== p[i]) begin failures++; $display("FAIL single_word%0d: got %h expected %h", i, out_q[i], p[i]); end
        end
        if (out_cyc.size() == 5) begin
            checks++; if (out_cyc[4] - out_cyc[0] != 4) begin failures++; $display("FAIL single_contiguous: got span %0d expected 4", out_cyc[4] - out_cyc[0]); end
        end
    endtask

    task automatic test_contention();
        word_q_t c1 = make_pkt(5);
        word_q_t p1 = make_pkt(5);
        word_q_t c2 = make_pkt(5);
        word_q_t exp;
        do_reset();
        data_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            conf_valid = 1'b1;
            conf_data = (i < 5) ? c1[i] : c2[i-5];
            pkt_valid = (i < 5);
            pkt_data = (i < 5) ? p1[i] : '0;
            tick();
        end
        conf_valid = 1'b0;
        pkt_valid = 1'b0;
        wait_out(15, 100);
        exp = {c1, p1, c2};
        checks++; if (out_q.size() != 15) begin failures++; $display("FAIL contention_count: got %0d expected 15", out_q.size()); end
        for (int i = 0; i < 15 && i < out_q.size(); i++) begin
            checks++; if (out_q[i] !== exp[i]) begin failures++; $display("FAIL contention_word%0d: got %h expected %h", i, out_q[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        word_q_t p = make_pkt(8);
        int hold = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            conf_valid = (c < 8);
            conf_data = (c < 8) ? p[c] : '0;
            data_out_ready = !(c >= 5 && c < 15);
            if (c == 5) hold = (out_q.size() < 8) ? out_q.size() : 7;
            if (c >= 5 && c < 15) begin
                checks++;
                if (data_out_valid !== 1'b1 || data_out !== p[hold]) begin
                    failures++; $display("FAIL hold_c%0d: got valid=%b data=%h expected valid=1 data=%h", c, data_out_valid, data_out, p[hold]);
                end
            end
            tick();
        end
        wait_out(8, 50);
        checks++; if (out_q.size() != 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", out_q.size()); end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            checks++; if (out_q[i] !== p[i]) begin failures++; $display("FAIL bp_word%0d: got %h expected %h", i, out_q[i], p[i]); end
        end
    endtask

    task automatic test_drop();
        word_q_t fill;
        word_q_t dropped = make_pkt(5);
        word_q_t late = make_pkt(5);
        word_q_t exp;
        do_reset();
        for (int k = 0; k < 4; k++) fill = {fill, make_pkt(5)};
        fill = {fill, make_pkt(6)};
        for (int i = 0; i < fill.size(); i++) begin
            pkt_valid = 1'b1; pkt_data = fill[i]; tick();
        end
        pkt_valid = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            pkt_valid = 1'b1; pkt_data = dropped[i]; tick();
        end
        pkt_valid = 1'b0;
        repeat (3) tick();
        checks++; if (drop_cnt_pkt !== 16'd1) begin failures++; $display("FAIL drop_pkt: got %0d expected 1", drop_cnt_pkt); end
        checks++; if (drop_cnt_conf !== 16'd0) begin failures++; $display("FAIL drop_conf: got %0d expected 0", drop_cnt_conf); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL drop_err: got %0d expected 0", err_cnt); end
        data_out_ready = 1'b1;
        wait_out(26, 100);
        for (int i = 0; i < 5; i++) begin
            pkt_valid = 1'b1; pkt_data = late[i]; tick();
        end
        pkt_valid = 1'b0;
        wait_out(31, 100);
        repeat (5) tick();
        exp = {fill, late};
        checks++; if (out_q.size() != 31) begin failures++; $display("FAIL drop_out_count: got %0d expected 31", out_q.size()); end
        for (int i = 0; i < 31 && i < out_q.size(); i++) begin
            checks++; if (out_q[i] !== exp[i]) begin failures++; $display("FAIL drop_word%0d: got %h expected %h", i, out_q[i], exp[i]); end
        end
    endtask

    task automatic test_orphan_middle();
        do_reset();
        data_out_ready = 1'b1;
        conf_valid = 1'b1;
        conf_data = make_word(WT_MID);
        tick();
        conf_valid = 1'b0;
        repeat (6) tick();
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL orphan_err: got %0d expected 1", err_cnt); end
        checks++; if (out_q.size() != 0) begin failures++; $display("FAIL orphan_out: got %0d words expected 0", out_q.size()); end
    endtask

    task automatic test_reset_mid_packet();
        word_q_t p = make_pkt(8);
        word_q_t q = make_pkt(5);
        bit did_rst = 1'b0;
        do_reset();
        data_out_ready = 1'b1;
        pkt_valid = 1'b1;
        pkt_data = make_word(WT_TAIL);
        tick();
        pkt_valid = 1'b0;
        for (int c = 0; c < 30 && !did_rst; c++) begin
            conf_valid = (c < 8);
            conf_data = (c < 8) ? p[c] : '0;
            tick();
            if (data_out_valid === 1'b1 && data_out === p[2]) begin
                checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL pre_rst_err: got %0d expected 1", err_cnt); end
                conf_valid = 1'b0;
                reset = 1'b1;
                #1;
                checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", data_out_valid); end
                checks++; if (data_out !== 134'd0) begin failures++; $display("FAIL rst_data: got %h expected 0", data_out); end
                checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rst_err: got %0d expected 0", err_cnt); end
                did_rst = 1'b1;
            end
        end
        checks++; if (did_rst !== 1'b1) begin failures++; $display("FAIL rst_third_word: got not seen expected seen"); end
        conf_valid = 1'b0;
        tick();
        reset = 1'b0;
        out_q.delete();
        out_cyc.delete();
        tick();
        for (int i = 0; i < 5; i++) begin
            conf_valid = 1'b1; conf_data = q[i]; tick();
        end
        conf_valid = 1'b0;
        wait_out(5, 50);
        repeat (3) tick();
        checks++; if (out_q.size() != 5) begin failures++; $display("FAIL post_rst_count: got %0d expected 5", out_q.size()); end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            checks++; if (out_q[i] !== q[i]) begin failures++; $display("FAIL post_rst_word%0d: got %h expected %h", i, out_q[i], q[i]); end
        end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL post_rst_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_random();
        logic [133:0] expq[2][$];
        int left[2] = '{0, 0};
        int plen[2] = '{0, 0};
        int gap[2] = '{0, 0};
        int err_exp = 0;
        int total = 0;
        int cur = -1;
        logic [133:0] w;
        logic v;
        do_reset();
        for (int c = 0; c < 2000 || left[0] > 0 || left[1] > 0; c++) begin
            data_out_ready = ($urandom_range(0, 9) != 0);
            for (int s = 0; s < 2; s++) begin
                v = 1'b0;
                w = '0;
                if (left[s] > 0) begin
                    w = make_word(left[s] == plen[s] ? WT_HEAD : (left[s] == 1 ? WT_TAIL : WT_MID));
                    v = 1'b1;
                    expq[s].push_back(w);
                    left[s]--;
                    total++;
                end else if (gap[s] > 0) begin
                    gap[s]--;
                    if (c < 2000 && $urandom_range(0, 15) == 0) begin
                        w = make_word($urandom_range(0, 1) == 0 ? WT_MID : WT_TAIL);
                        v = 1'b1;
                        err_exp++;
                    end
                end else if (c < 2000) begin
                    plen[s] = $urandom_range(2, 8);
                    left[s] = plen[s];
                    gap[s] = $urandom_range(8, 16);
                end
                if (s == 0) begin conf_valid = v; conf_data = w; end
                else begin pkt_valid = v; pkt_data = w; end
            end
            tick();
        end
        conf_valid = 1'b0;
        pkt_valid = 1'b0;
        data_out_ready = 1'b1;
        wait_out(total, 2000);
        repeat (3) tick();
        checks++; if (out_q.size() != total) begin failures++; $display("FAIL rand_count: got %0d expected %0d", out_q.size(), total); end
        for (int i = 0; i < out_q.size(); i++) begin
            if (cur < 0) begin
                if (expq[0].size() > 0 && out_q[i] === expq[0][0]) cur = 0;
                else if (expq[1].size() > 0 && out_q[i] === expq[1][0]) cur = 1;
            end
            checks++;
            if (cur < 0 || expq[cur].size() == 0 || out_q[i] !== expq[cur][0]) begin
                failures++; $display("FAIL rand_word%0d: got %h expected next word of an open or waiting packet", i, out_q[i]);
                break;
            end
            void'(expq[cur].pop_front());
            if (out_q[i][133:132] == WT_TAIL) cur = -1;
        end
        checks++; if (expq[0].size() + expq[1].size() != 0) begin failures++; $display("FAIL rand_leftover: got %0d undelivered expected 0", expq[0].size() + expq[1].size()); end
        checks++; if (err_cnt !== 16'(err_exp)) begin failures++; $display("FAIL rand_err: got %0d expected %0d", err_cnt, err_exp); end
        checks++; if (drop_cnt_conf !== 16'd0 || drop_cnt_pkt !== 16'd0) begin failures++; $display("FAIL rand_drops: got %0d/%0d expected 0/0", drop_cnt_conf, drop_cnt_pkt); end
    endtask

    initial begin
        test_reset();
        test_single_conf();
        test_contention();
        test_backpressure();
        test_drop();
        test_orphan_middle();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
